// File: rtl/shift_add_multiplier_if.sv
// rtl/shift_add_multiplier_if.sv - start/ready/done handshake plus external adder bus for shift_add_multiplier
interface shift_add_multiplier_if #(
  parameter int SIZE = 8
);
  logic              start;
  logic [SIZE-1:0]   mcand;
  logic [SIZE-1:0]   mplier;
  logic              ready;
  logic              done;
  logic [2*SIZE-1:0] product;
  logic [SIZE-1:0]   add_a;
  logic [SIZE-1:0]   add_b;
  logic              add_ci;
  logic [SIZE-1:0]   add_sum;
  logic              add_co;

  // slave: the multiplier; master: the requester that also owns the adder
  modport slave (
    input  start, mcand, mplier, add_sum, add_co,
    output ready, done, product, add_a, add_b, add_ci
  );

  modport master (
    output start, mcand, mplier, add_sum, add_co,
    input  ready, done, product, add_a, add_b, add_ci
  );
endinterface

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential unsigned shift-add multiplier driving an external SIZE-bit adder
module shift_add_multiplier #(
  parameter int SIZE = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  shift_add_multiplier_if.slave bus
);
  localparam int CW = $clog2(SIZE) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SIZE - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SIZE-1:0]     r_m;
  logic [SIZE-1:0]     r_a;
  logic [SIZE-1:0]     r_q;
  logic [CW-1:0]       r_cnt;
  logic                r_done;
  logic [2*SIZE-1:0]   r_product;
  logic [SIZE-1:0]     w_add_a;
  logic [SIZE-1:0]     w_add_b;
  logic                w_last;
  logic [SIZE-1:0]     w_a_nxt;
  logic [SIZE-1:0]     w_q_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_add_a     = '0;
    w_add_b     = '0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_add_a = r_a;
        w_add_b = r_q[0] ? r_m : '0;
        w_last  = (r_cnt == CNT_LAST);
        if (w_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // {A,Q} shifted right by one with the adder carry entering A's MSB
  assign w_a_nxt = {bus.add_co, bus.add_sum[SIZE-1:1]};
  assign w_q_nxt = {bus.add_sum[0], r_q[SIZE-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m       <= '0;
      r_a       <= '0;
      r_q       <= '0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_m   <= bus.mcand;
            r_q   <= bus.mplier;
            r_a   <= '0;
            r_cnt <= '0;
          end
        end
        S_RUN: begin
          r_a   <= w_a_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_product <= {w_a_nxt, w_q_nxt};
            r_done    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready   = (r_state == S_IDLE);
  assign bus.done    = r_done;
  assign bus.product = r_product;
  assign bus.add_a   = w_add_a;
  assign bus.add_b   = w_add_b;
  assign bus.add_ci  = 1'b0;
endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
- Sequential unsigned multiplier that drives an external SIZE-bit ripple-carry adder and consumes its result.
- Sits upstream and downstream of the adder: each cycle it presents a partial-product addition on add_a/add_b/add_ci, then captures add_sum/add_co in the same cycle.
- Computes a SIZE x SIZE product in SIZE cycles, using a start/ready/done handshake.

Parameters:
- SIZE, 8, operand width and external adder width (must be >= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when ready=1.
- mcand  input  SIZE  multiplicand; captured on the accepted start edge.
- mplier  input  SIZE  multiplier; captured on the accepted start edge.
- ready  output  1  high when idle and able to accept start.
- done  output  1  one-cycle pulse when product is valid.
- product  output  2*SIZE  registered result; held until the next completion or reset.
- add_a  output  SIZE  adder operand A (accumulator).
- add_b  output  SIZE  adder operand B (gated multiplicand).
- add_ci  output  1  adder carry-in; constant 0.
- add_sum  input  SIZE  adder sum; combinational return from the adder.
- add_co  input  1  adder carry-out.

Behaviour:
- One clock domain; reset is asynchronous and active-low.
- Internal registers:
  - M (SIZE): multiplicand.
  - A (SIZE): accumulator.
  - Q (SIZE): multiplier/low product.
  - cnt: width clog2(SIZE)+1.
  - state: IDLE or RUN.
- Reset (rst_n=0, async, any time including mid-RUN):
  - state=IDLE; A=Q=M=0; cnt=0; done=0; product=0.
  - Outputs follow: ready=1, add_a=0, add_b=0, add_ci=0.
- ready = (state==IDLE), combinational.
- IDLE:
  - If start=1 at an edge: M<=mcand, Q<=mplier, A<=0, cnt<=0, state<=RUN.
  - Otherwise all registers hold.
- RUN, combinational outputs:
  - add_a = A.
  - add_b = Q[0] ? M : 0.
  - add_ci = 0.
- RUN, each edge: {A,Q} <= {add_co, add_sum, Q} >> 1, i.e.:
  - A <= {add_co, add_sum[SIZE-1:1]}
  - Q <= {add_sum[0], Q[SIZE-1:1]}
  - cnt <= cnt+1.
- Completion: on the RUN edge where cnt==SIZE-1:
  - product <= the shifted {A,Q} value computed on that edge.
  - done <= 1.
  - state <= IDLE.
- In IDLE, add_a=0 and add_b=0.
- done is cleared on every edge that does not complete an operation, so it is exactly one cycle wide.
- Latency: start accepted at edge E0; steps occur on edges E1..ESIZE; product and done update at ESIZE. done and ready are both high in the cycle after ESIZE.
- Back-to-back: start=1 during the done cycle is accepted (ready=1 there). product keeps the old value until the next completion.
- start while RUN is ignored. mcand/mplier changes during RUN have no effect.
- Arithmetic is unsigned; the product never overflows 2*SIZE bits. The adder is assumed combinational within one cycle.

Test Plan:
- SIZE=8, reset then start with mcand=13, mplier=11 -> done pulses exactly 8 edges after the start edge; product=16'd143; ready=0 during the 8 RUN cycles.
- mcand=8'hFF, mplier=8'hFF -> product=16'hFE01; add_co=1 must be observed on at least one RUN step and shifted into A.
- mcand=8'hA5, mplier=0 -> add_b=0 every RUN cycle; product=0. Then mcand=8'h5A, mplier=1 -> product=16'h005A.
- Back-to-back: start held high through the done cycle with new operands 200 x 3 -> first product valid, second done 8 edges later with product=16'd600; done is never high for 2 consecutive cycles.
- start pulsed mid-RUN with different operands -> ignored; result matches the original operands.
- rst_n dropped asynchronously (between edges) at RUN step 4 -> immediately product=0, done=0, ready=1, add_a=add_b=0. After release, a fresh 7 x 9 gives product=63.
